// File: rtl/valve_scheduler.sv
// valve_scheduler: serialises reward-valve deliveries for four maze valves.
// Requests are latched into a pending mask and arbitrated round-robin. Each
// delivery plays out as N pulses of a programmed length, with a fixed closed
// gap after every pulse. At most one valve is open at any time.
//
// Optional feature (macro VALVE_SCHED_STATS_EN): adds deliv_count_o, a
// per-valve saturating count of completed pulses.
//
// Ports:
//   clk_i          system clock (1 MHz)
//   rst_ni         asynchronous active-low reset
//   req_i          per-valve request; each high cycle is one request
//   abort_i        cancel the current delivery and every pending request
//   pulse_len_i    per-valve open time in cycles; valve i at [i*LEN_W +: LEN_W]
//   repeat_cnt_i   per-valve pulse count, 0 treated as 1; valve i at [i*REP_W +: REP_W]
//   valve_o        registered valve drive, at most one bit set
//   busy_o         high while a delivery is in progress (OPEN or GAP)
//   pending_o      latched requests that have not been granted yet
//   active_idx_o   valve currently or most recently served
//   deliv_count_o  (stats build only) 16-bit completed-pulse count per valve
module valve_scheduler #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [3:0]         req_i,
  input  logic               abort_i,
  input  logic [4*LEN_W-1:0] pulse_len_i,
  input  logic [4*REP_W-1:0] repeat_cnt_i,
  output logic [3:0]         valve_o,
  output logic               busy_o,
  output logic [3:0]         pending_o,
  output logic [1:0]         active_idx_o
`ifdef VALVE_SCHED_STATS_EN
  ,
  output logic [4*16-1:0]    deliv_count_o
`endif
);

  // One down-counter serves both phases, so it must hold the larger of the
  // maximum pulse length and the gap length.
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CntW = (LEN_W > GapW) ? LEN_W : GapW;
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES);

  typedef enum logic [1:0] {StIdle, StOpen, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        valve_q, valve_d;

  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [3:0]        pending_clr;
  logic [LEN_W-1:0]  len_sel;
  logic [REP_W-1:0]  rep_sel;

  // Round-robin search starting just after the last granted valve.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign len_sel = pulse_len_i[grant_idx*LEN_W +: LEN_W];
  assign rep_sel = repeat_cnt_i[grant_idx*REP_W +: REP_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    reps_d      = reps_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    pending_clr = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          pending_clr[grant_idx] = 1'b1;
          idx_d = grant_idx;
          ptr_d = grant_idx;
          len_d = len_sel;
          // A zero-length request is consumed here without opening anything.
          if (len_sel != '0) begin
            state_d = StOpen;
            cnt_d   = CntW'(len_sel);
            reps_d  = (rep_sel == '0) ? REP_W'(1) : rep_sel;
          end
        end
      end
      StOpen: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StGap;
          cnt_d   = GapLoad;
          reps_d  = reps_q - REP_W'(1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(1)) begin
          if (reps_q != '0) begin
            state_d = StOpen;
            cnt_d   = CntW'(len_q);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A new request beats a same-cycle grant clear of the same bit.
    pending_d = (pending_q & ~pending_clr) | req_i;

    if (abort_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      reps_d    = '0;
      pending_d = '0;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
    end

    valve_d = (state_d == StOpen) ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd3;
      pending_q <= '0;
      valve_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      valve_q   <= valve_d;
    end
  end

  assign valve_o      = valve_q;
  assign busy_o       = (state_q != StIdle);
  assign pending_o    = pending_q;
  assign active_idx_o = idx_q;

`ifdef VALVE_SCHED_STATS_EN
  logic [3:0][15:0] deliv_q;
  logic             pulse_done;

  // Abort forces state_d to idle, so an interrupted pulse never counts.
  assign pulse_done = (state_q == StOpen) && (state_d == StGap);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deliv_q <= '0;
    end else if (pulse_done && (deliv_q[idx_q] != 16'hFFFF)) begin
      deliv_q[idx_q] <= deliv_q[idx_q] + 16'd1;
    end
  end

  assign deliv_count_o = deliv_q;
`endif

endmodule

// File: tb/tb_valve_scheduler.sv
// Directed bench for valve_scheduler: reset state, single delivery timing,
// repeats, round-robin order, re-requests, abort, zero length, config change
// mid-pulse and asynchronous reset mid-pulse.
module tb_valve_scheduler;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned REP_W = 4;
  localparam int unsigned GAP   = 1000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req = '0;
  logic               abort = 1'b0;
  logic [4*LEN_W-1:0] pulse_len = '0;
  logic [4*REP_W-1:0] repeat_cnt = '0;
  logic [3:0]         valve;
  logic               busy;
  logic [3:0]         pending;
  logic [1:0]         active_idx;
`ifdef VALVE_SCHED_STATS_EN
  logic [63:0]        deliv;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  valve_scheduler #(
    .LEN_W      (LEN_W),
    .REP_W      (REP_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .abort_i      (abort),
    .pulse_len_i  (pulse_len),
    .repeat_cnt_i (repeat_cnt),
    .valve_o      (valve),
    .busy_o       (busy),
    .pending_o    (pending),
    .active_idx_o (active_idx)
`ifdef VALVE_SCHED_STATS_EN
    ,
    .deliv_count_o (deliv)
`endif
  );

  always #5 clk = ~clk;

  // Two valves open together is never legal.
  always @(negedge clk) begin
    if (rst_n && !$onehot0(valve)) viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int i, input int l, input int r);
    pulse_len[i*LEN_W +: LEN_W]  = LEN_W'(l);
    repeat_cnt[i*REP_W +: REP_W] = REP_W'(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    abort = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  // One-cycle request pulse; returns one tick after the latch edge.
  task automatic pulse_req(input logic [3:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_cfg(i, 20, 1);

    // Reset values, checked between clock edges while reset is held.
    #23;
    check("rst_valve", valve, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_idx", active_idx, 0);
    tick();
    rst_n = 1'b1;
    tick(2);

    // Single request: 50-cycle pulse, then 1000-cycle gap.
    set_cfg(0, 50, 0);
    pulse_req(4'b0001);
    check("s_pend", pending, 4'b0001);
    check("s_busy_arb", busy, 0);
    tick();
    check("s_valve_on", valve, 4'b0001);
    check("s_busy_on", busy, 1);
    check("s_pend_clr", pending, 0);
    tick(49);
    check("s_valve_last", valve, 4'b0001);
    tick();
    check("s_valve_off", valve, 0);
    check("s_busy_gap0", busy, 1);
    tick(999);
    check("s_busy_gap_end", busy, 1);
    tick();
    check("s_idle", busy, 0);

    // Three 10-cycle pulses on valve 1.
    set_cfg(1, 10, 3);
    pulse_req(4'b0010);
    check("r_pend", pending, 4'b0010);
    tick();
    check("r_grant", valve, 4'b0010);
    check("r_pend_clr", pending, 0);
    check("r_idx", active_idx, 1);
    for (int p = 0; p < 3; p++) begin
      tick(9);
      check("r_on", valve, 4'b0010);
      tick();
      check("r_off", valve, 0);
      tick(999);
      check("r_gap", {busy, valve}, {1'b1, 4'b0000});
      tick();
      if (p < 2) check("r_reopen", valve, 4'b0010);
      else check("r_idle", busy, 0);
    end
`ifdef VALVE_SCHED_STATS_EN
    check("st_v0", deliv[15:0], 1);
    check("st_v1", deliv[31:16], 3);
`endif

    // Round-robin from reset: 1 before 3, then 0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) set_cfg(i, 20, 1);
    pulse_req(4'b1010);
    tick();
    check("rr_first", valve, 4'b0010);
    check("rr_first_idx", active_idx, 1);
    check("rr_pend3", pending, 4'b1000);
    tick(1020);
    check("rr_idle_gap", {busy, valve, pending}, {1'b0, 4'b0000, 4'b1000});
    tick();
    check("rr_second", valve, 4'b1000);
    check("rr_second_idx", active_idx, 3);
    tick(1020);
    check("rr_idle2", busy, 0);
    pulse_req(4'b1111);
    tick();
    check("rr_all_0", valve, 4'b0001);
    check("rr_all_pend", pending, 4'b1110);
    for (int k = 1; k < 4; k++) begin
      tick(1021);
      check("rr_all_k", valve, 4'b0001 << k);
    end
    tick(1020);
    check("rr_all_done", {busy, pending}, 0);

    // Re-requests: one in the grant cycle, one during OPEN.
    set_cfg(2, 20, 1);
    req = 4'b0100;
    tick();
    tick();
    req = '0;
    check("rq_grant", valve, 4'b0100);
    check("rq_keep", pending, 4'b0100);
    tick(1021);
    check("rq_second", valve, 4'b0100);
    check("rq_second_pend", pending, 0);
    tick(5);
    pulse_req(4'b0100);
    check("rq_open_pend", pending, 4'b0100);
    tick(1015);
    check("rq_third", valve, 4'b0100);
    check("rq_third_pend", pending, 0);
    tick(1020);
    check("rq_done", busy, 0);

    // Abort mid-OPEN with pending 1010 and a same-cycle request.
    do_reset();
    set_cfg(0, 50, 1);
    set_cfg(3, 5, 1);
    pulse_req(4'b0001);
    tick();
    check("ab_open", valve, 4'b0001);
    tick(3);
    pulse_req(4'b1010);
    check("ab_pend", pending, 4'b1010);
    tick(2);
    abort = 1'b1;
    req   = 4'b0100;
    tick();
    abort = 1'b0;
    req   = '0;
    check("ab_state", {valve, pending, busy}, 0);
    check("ab_idx", active_idx, 0);
    tick(5);
    check("ab_quiet", {valve, busy}, 0);
`ifdef VALVE_SCHED_STATS_EN
    check("ab_stat", deliv, 0);
`endif
    // Pointer kept at 0, so valve 3 wins over valve 0.
    pulse_req(4'b1001);
    tick();
    check("ab_ptr", {active_idx, valve}, {2'd3, 4'b1000});
    tick(1005);
    check("ab_ptr_idle", {busy, pending}, {1'b0, 4'b0001});
    tick();
    check("ab_ptr_next", valve, 4'b0001);
    tick(1050);
    check("ab_done", busy, 0);

    // Zero length: request consumed, nothing opens.
    set_cfg(3, 0, 1);
    pulse_req(4'b1000);
    tick();
    check("z_state", {valve, pending, busy}, 0);
    check("z_idx", active_idx, 3);
    tick(3);
    check("z_quiet", {valve, busy}, 0);
    // Dropped grant on 2 lets 3 win on the very next cycle.
    set_cfg(2, 0, 1);
    set_cfg(3, 5, 1);
    pulse_req(4'b1100);
    tick();
    check("z_drop", {active_idx, valve, pending}, {2'd2, 4'b0000, 4'b1000});
    tick();
    check("z_next", {active_idx, valve}, {2'd3, 4'b1000});
    tick(1005);
    check("z_done", busy, 0);

    // Config change mid-pulse has no effect.
    set_cfg(1, 30, 1);
    pulse_req(4'b0010);
    tick();
    check("c_open", valve, 4'b0010);
    tick(3);
    set_cfg(1, 5, 7);
    tick(26);
    check("c_hold", valve, 4'b0010);
    tick();
    check("c_off", valve, 0);
    tick(1000);
    check("c_idle", {busy, valve}, 0);

    // Asynchronous reset closes the valve without a clock edge.
    set_cfg(0, 50, 1);
    pulse_req(4'b0001);
    tick();
    tick(5);
    check("ar_open", valve, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_closed", {valve, busy}, 0);
`ifdef VALVE_SCHED_STATS_EN
    check("ar_stat", deliv, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    check("onehot", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
